// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Produces stage enables/flushes for memory waits, taken branches and
// load-use (or, without forwarding, any RAW) hazards, keeps saturating
// stall/flush counters and a sticky memory-wait timeout flag.
// Optional feature macro: HAZARD_FWD_EN enables EX-stage operand forwarding
// from MEM/WB; when undefined, forward selects are tied to 00 and every
// in-flight EX/MEM producer stalls a dependent ID instruction instead.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs1,
  input  logic [4:0]  D_rs2,
  input  logic [4:0]  E_rs1,
  input  logic [4:0]  E_rs2,
  input  logic [4:0]  E_rd,
  input  logic        E_reg_write,
  input  logic        E_mem_read,
  input  logic [4:0]  M_rd,
  input  logic        M_reg_write,
  input  logic [4:0]  W_rd,
  input  logic        W_reg_write,
  input  logic        E_pc_src,
  input  logic        M_mem_req,
  input  logic        M_mem_ready,
  output logic        F_en,
  output logic        D_en,
  output logic        D_clr,
  output logic        E_en,
  output logic        E_clr,
  output logic        M_en,
  output logic [1:0]  E_fwdA,
  output logic [1:0]  E_fwdB,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic        mem_timeout
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_inc;
  logic        r_timeout;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic        w_mem_stall;
  logic        w_load_use;
  logic        w_flush_evt;

  // A producer hazard: write-enabled destination that is not x0 and matches rs.
  function automatic logic rd_hit(input logic [4:0] rs, input logic [4:0] rd,
                                  input logic wr);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A data access that is pending but not completing freezes the whole pipe.
  assign w_mem_stall = M_mem_req & ~M_mem_ready;

  // Wait counter never wraps, so the timeout flag cannot be missed.
  assign w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;

`ifdef HAZARD_FWD_EN
  logic w_unused_fwd;

  // Only a load result is too late to forward; everything else is bypassed.
  assign w_load_use = rd_hit(D_rs1, E_rd, E_mem_read) |
                      rd_hit(D_rs2, E_rd, E_mem_read);

  // E_reg_write only matters to the stall logic of the non-forwarding build.
  assign w_unused_fwd = E_reg_write;

  // MEM result is younger than WB result, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rd_hit(rs, M_rd, M_reg_write))
      return 2'b10;
    else if (rd_hit(rs, W_rd, W_reg_write))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Operand select for the ALU inputs; held at regfile during reset.
  always_comb begin
    E_fwdA = 2'b00;
    E_fwdB = 2'b00;
    if (!rst) begin
      E_fwdA = fwd_sel(E_rs1);
      E_fwdB = fwd_sel(E_rs2);
    end
  end
`else
  logic w_unused_fwd;

  // Without bypassing, a dependency on any EX or MEM producer (or a load in
  // EX) must wait; WB writes the regfile early enough to need no stall.
  assign w_load_use = rd_hit(D_rs1, E_rd, E_mem_read)  |
                      rd_hit(D_rs2, E_rd, E_mem_read)  |
                      rd_hit(D_rs1, E_rd, E_reg_write) |
                      rd_hit(D_rs2, E_rd, E_reg_write) |
                      rd_hit(D_rs1, M_rd, M_reg_write) |
                      rd_hit(D_rs2, M_rd, M_reg_write);

  // Forwarding-only inputs are unused in this build.
  assign w_unused_fwd = ^{E_rs1, E_rs2, W_rd, W_reg_write};

  // Operands always come from the register file.
  always_comb begin
    E_fwdA = 2'b00;
    E_fwdB = 2'b00;
  end
`endif

  // Next state and stage controls; priority: reset, memory stall, flush, load-use.
  always_comb begin
    w_state_nxt = r_state;
    F_en        = 1'b1;
    D_en        = 1'b1;
    D_clr       = 1'b0;
    E_en        = 1'b1;
    E_clr       = 1'b0;
    M_en        = 1'b1;
    w_flush_evt = 1'b0;

    case (r_state)
      ST_RUN:     if (w_mem_stall)  w_state_nxt = ST_MEMWAIT;
      ST_MEMWAIT: if (!w_mem_stall) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase

    if (rst) begin
      D_clr = 1'b1;
      E_clr = 1'b1;
    end else if (w_mem_stall) begin
      F_en = 1'b0;
      D_en = 1'b0;
      E_en = 1'b0;
      M_en = 1'b0;
    end else if (E_pc_src) begin
      // A branch held across a memory stall lands here on the first free cycle.
      D_clr       = 1'b1;
      E_clr       = 1'b1;
      w_flush_evt = 1'b1;
    end else if (w_load_use) begin
      F_en  = 1'b0;
      D_en  = 1'b0;
      E_clr = 1'b1;
    end
  end

  // State register, wait timer, timeout flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait      <= 8'd0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && (w_state_nxt == ST_MEMWAIT)) begin
        r_wait <= 8'd0;
      end else if ((r_state == ST_MEMWAIT) && (w_state_nxt == ST_MEMWAIT)) begin
        r_wait <= w_wait_inc;
        if (w_wait_inc == 8'hFF)
          r_timeout <= 1'b1;
      end
      if (!F_en)
        r_stall_cnt <= sat_inc32(r_stall_cnt);
      if (w_flush_evt)
        r_flush_cnt <= sat_inc32(r_flush_cnt);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;
  assign mem_timeout  = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle sequences
// and randomized cycles against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_rs1, D_rs2, E_rs1, E_rs2, E_rd, M_rd, W_rd;
  logic        E_reg_write, E_mem_read, M_reg_write, W_reg_write;
  logic        E_pc_src, M_mem_req, M_mem_ready;
  logic        F_en, D_en, D_clr, E_en, E_clr, M_en;
  logic [1:0]  E_fwdA, E_fwdB;
  logic [31:0] stall_cycles, flush_count;
  logic        mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // control vector order: {F_en, D_en, D_clr, E_en, E_clr, M_en}
  localparam logic [5:0] C_NORM  = 6'b110101;
  localparam logic [5:0] C_LU    = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_MEM   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b111111;

  typedef struct {
    logic [4:0] d1, d2, e1, e2, erd, mrd, wrd;
    logic       emr, erw, mrw, wrw, pc, mreq, mrdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [5:0] ctl;
    logic [3:0] fwd;
  } vec_t;

  typedef struct {
    logic [5:0] ctl;
    logic [3:0] fwd;
  } exp_t;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .D_rs1(D_rs1), .D_rs2(D_rs2),
    .E_rs1(E_rs1), .E_rs2(E_rs2), .E_rd(E_rd),
    .E_reg_write(E_reg_write), .E_mem_read(E_mem_read),
    .M_rd(M_rd), .M_reg_write(M_reg_write),
    .W_rd(W_rd), .W_reg_write(W_reg_write),
    .E_pc_src(E_pc_src), .M_mem_req(M_mem_req), .M_mem_ready(M_mem_ready),
    .F_en(F_en), .D_en(D_en), .D_clr(D_clr), .E_en(E_en), .E_clr(E_clr), .M_en(M_en),
    .E_fwdA(E_fwdA), .E_fwdB(E_fwdB),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic in_t mkin(
    input logic [4:0] d1, d2, e1, e2, erd, input logic emr, erw,
    input logic [4:0] mrd, input logic mrw, input logic [4:0] wrd, input logic wrw,
    input logic pc, mreq, mrdy);
    in_t v;
    v.d1 = d1; v.d2 = d2; v.e1 = e1; v.e2 = e2; v.erd = erd;
    v.emr = emr; v.erw = erw; v.mrd = mrd; v.mrw = mrw;
    v.wrd = wrd; v.wrw = wrw; v.pc = pc; v.mreq = mreq; v.mrdy = mrdy;
    return v;
  endfunction

  task automatic drive(input in_t v);
    D_rs1 = v.d1; D_rs2 = v.d2; E_rs1 = v.e1; E_rs2 = v.e2; E_rd = v.erd;
    E_mem_read = v.emr; E_reg_write = v.erw; M_rd = v.mrd; M_reg_write = v.mrw;
    W_rd = v.wrd; W_reg_write = v.wrw; E_pc_src = v.pc;
    M_mem_req = v.mreq; M_mem_ready = v.mrdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {F_en, D_en, D_clr, E_en, E_clr, M_en};
  endfunction

  // Reference model: the hazard rules written directly as arithmetic on fields.
  function automatic bit dep(input in_t v, input logic [4:0] rs);
    if (rs == 0) return 0;
    if (v.emr && v.erd == rs) return 1;
    if (!FWD && v.erw && v.erd == rs) return 1;
    if (!FWD && v.mrw && v.mrd == rs) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] src(input in_t v, input logic [4:0] rs);
    if (!FWD || rs == 0) return 2'd0;
    if (v.mrw && v.mrd == rs) return 2'd2;
    if (v.wrw && v.wrd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model(input in_t v, input logic r);
    exp_t e;
    e.fwd = r ? 4'd0 : {src(v, v.e1), src(v, v.e2)};
    if (r)                            e.ctl = C_RST;
    else if (v.mreq && !v.mrdy)       e.ctl = C_MEM;
    else if (v.pc)                    e.ctl = C_FLUSH;
    else if (dep(v, v.d1) || dep(v, v.d2)) e.ctl = C_LU;
    else                              e.ctl = C_NORM;
    return e;
  endfunction

  in_t idle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(idle);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t  t;
    in_t   v;
    exp_t  e;
    longint m_stall, m_flush;
    int     m_run;
    bit     m_to;
    bit     r;

    idle = mkin(0,0,0,0,0, 0,0, 0,0, 0,0, 0,0,0);
    rst  = 1'b1;
    drive(idle);

    // Directed single-cycle table
    t.name="idle";          t.v=idle;                                   t.ctl=C_NORM;  t.fwd=0; vecs.push_back(t);
    t.name="lu_rs1";        t.v=mkin(5,0,0,0,5, 1,1, 0,0, 0,0, 0,0,0);  t.ctl=C_LU;    t.fwd=0; vecs.push_back(t);
    t.name="lu_rs2";        t.v=mkin(0,9,0,0,9, 1,1, 0,0, 0,0, 0,0,0);  t.ctl=C_LU;    t.fwd=0; vecs.push_back(t);
    t.name="lu_x0";         t.v=mkin(0,0,0,0,0, 1,1, 0,0, 0,0, 0,0,0);  t.ctl=C_NORM;  t.fwd=0; vecs.push_back(t);
    t.name="lu_nomatch";    t.v=mkin(6,7,0,0,5, 1,1, 0,0, 0,0, 0,0,0);  t.ctl=C_NORM;  t.fwd=0; vecs.push_back(t);
    t.name="flush_over_lu"; t.v=mkin(5,0,0,0,5, 1,1, 0,0, 0,0, 1,0,0);  t.ctl=C_FLUSH; t.fwd=0; vecs.push_back(t);
    t.name="mem_over_all";  t.v=mkin(5,0,0,0,5, 1,1, 0,0, 0,0, 1,1,0);  t.ctl=C_MEM;   t.fwd=0; vecs.push_back(t);
    t.name="mem_ready";     t.v=mkin(0,0,0,0,0, 0,0, 0,0, 0,0, 0,1,1);  t.ctl=C_NORM;  t.fwd=0; vecs.push_back(t);
    t.name="raw_ex_alu";    t.v=mkin(3,0,0,0,3, 0,1, 0,0, 0,0, 0,0,0);  t.ctl=FWD ? C_NORM : C_LU; t.fwd=0; vecs.push_back(t);
    t.name="raw_mem";       t.v=mkin(0,4,4,0,0, 0,0, 4,1, 0,0, 0,0,0);  t.ctl=FWD ? C_NORM : C_LU; t.fwd=FWD ? 4'b1000 : 4'b0000; vecs.push_back(t);
    t.name="wb_fwdB";       t.v=mkin(6,0,0,6,0, 0,0, 0,0, 6,1, 0,0,0);  t.ctl=C_NORM;  t.fwd=FWD ? 4'b0001 : 4'b0000; vecs.push_back(t);
    t.name="mem_over_wb";   t.v=mkin(0,0,7,0,0, 0,0, 7,1, 7,1, 0,0,0);  t.ctl=C_NORM;  t.fwd=FWD ? 4'b1000 : 4'b0000; vecs.push_back(t);
    t.name="fwd_x0";        t.v=mkin(0,0,0,0,0, 0,0, 0,1, 0,1, 0,0,0);  t.ctl=C_NORM;  t.fwd=0; vecs.push_back(t);
    t.name="wb_when_m_off"; t.v=mkin(0,0,7,7,0, 0,0, 7,0, 7,1, 0,0,0);  t.ctl=C_NORM;  t.fwd=FWD ? 4'b0101 : 4'b0000; vecs.push_back(t);

    // Reset state and outputs while reset is asserted
    tick();
    chk("rst_ctl", ctl_now(), C_RST);
    chk("rst_fwd", {E_fwdA, E_fwdB}, 4'd0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_timeout", mem_timeout, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v);
      #1;
      chk({vecs[i].name, "_ctl"}, ctl_now(), vecs[i].ctl);
      chk({vecs[i].name, "_fwd"}, {E_fwdA, E_fwdB}, vecs[i].fwd);
      @(negedge clk);
    end

    // Load-use: one stalled cycle counted
    do_reset();
    drive(mkin(5,0,0,0,5, 1,1, 0,0, 0,0, 0,0,0));
    #1;
    chk("lu_seq_ctl", ctl_now(), C_LU);
    chk("lu_seq_stall0", stall_cycles, 0);
    tick();
    drive(idle);
    #1;
    chk("lu_seq_stall1", stall_cycles, 1);
    chk("lu_seq_after", ctl_now(), C_NORM);

    // Flush beats load-use
    do_reset();
    drive(mkin(5,0,0,0,5, 1,1, 0,0, 0,0, 1,0,0));
    #1;
    chk("fl_seq_ctl", ctl_now(), C_FLUSH);
    tick();
    drive(idle);
    #1;
    chk("fl_seq_flush", flush_count, 1);
    chk("fl_seq_stall", stall_cycles, 0);

    // Memory wait of three cycles
    do_reset();
    v = idle; v.mreq = 1; v.mrdy = 0;
    drive(v);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mw_ctl%0d", k), ctl_now(), C_MEM);
      tick();
    end
    v.mrdy = 1;
    drive(v);
    #1;
    chk("mw_ready_ctl", ctl_now(), C_NORM);
    tick();
    drive(idle);
    #1;
    chk("mw_stall", stall_cycles, 3);

    // Branch held across a memory stall flushes on the first free cycle
    do_reset();
    v = idle; v.pc = 1; v.mreq = 1; v.mrdy = 0;
    drive(v);
    #1;
    chk("pend_ctl0", ctl_now(), C_MEM);
    tick();
    chk("pend_ctl1", ctl_now(), C_MEM);
    tick();
    chk("pend_flush_held", flush_count, 0);
    v.mrdy = 1;
    drive(v);
    #1;
    chk("pend_issue", ctl_now(), C_FLUSH);
    tick();
    drive(idle);
    #1;
    chk("pend_flush", flush_count, 1);
    chk("pend_stall", stall_cycles, 2);

    // Timeout after 256 stalled cycles, sticky, cleared only by reset
    do_reset();
    v = idle; v.mreq = 1; v.mrdy = 0;
    drive(v);
    repeat (255) tick();
    chk("to_255", mem_timeout, 0);
    tick();
    chk("to_256", mem_timeout, 1);
    chk("to_stall", stall_cycles, 256);
    drive(idle);
    tick();
    chk("to_sticky", mem_timeout, 1);
    drive(v);
    rst = 1'b1;
    #1;
    chk("to_rst_ctl", ctl_now(), C_RST);
    tick();
    rst = 1'b0;
    drive(idle);
    #1;
    chk("to_rst_flag", mem_timeout, 0);
    chk("to_rst_stall", stall_cycles, 0);
    chk("to_rst_flush", flush_count, 0);
    drive(v);
    repeat (255) tick();
    chk("to_fresh_255", mem_timeout, 0);
    drive(idle);
    tick();

    // Randomized cycles against the reference model
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    for (int i = 0; i < 3000; i++) begin
      v.d1  = 5'($urandom_range(0, 7)); v.d2 = 5'($urandom_range(0, 7));
      v.e1  = 5'($urandom_range(0, 7)); v.e2 = 5'($urandom_range(0, 7));
      v.erd = 5'($urandom_range(0, 7)); v.mrd = 5'($urandom_range(0, 7));
      v.wrd = 5'($urandom_range(0, 7));
      v.emr = 1'($urandom_range(0, 1)); v.erw = 1'($urandom_range(0, 1));
      v.mrw = 1'($urandom_range(0, 1)); v.wrw = 1'($urandom_range(0, 1));
      v.pc  = ($urandom_range(0, 3) == 0);
      v.mreq = ($urandom_range(0, 2) == 0);
      v.mrdy = 1'($urandom_range(0, 1));
      r = (i == 0) || ($urandom_range(0, 39) == 0);
      drive(v);
      rst = r;
      #1;
      if (i > 0) begin
        e = model(v, r);
        chk("rnd_ctl", ctl_now(), e.ctl);
        chk("rnd_fwd", {E_fwdA, E_fwdB}, e.fwd);
        chk("rnd_stall", stall_cycles, 32'(m_stall));
        chk("rnd_flush", flush_count, 32'(m_flush));
        chk("rnd_timeout", mem_timeout, m_to);
      end
      e = model(v, r);
      if (r) begin
        m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
      end else begin
        if (!e.ctl[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (!(v.mreq && !v.mrdy) && v.pc && m_flush < 64'hFFFF_FFFF) m_flush++;
        if (v.mreq && !v.mrdy) m_run++;
        else m_run = 0;
        if (m_run >= 256) m_to = 1;
      end
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
